// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit:
// FSM states, opcodes, ALU codes, datapath select encodings and per-state outputs.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_EXECU,
        S_JAL,
        S_JALR,
        S_BRANCH,
        S_ALUWB
    } state_t;

    typedef enum logic [2:0] {
        CLS_ADD,
        CLS_ALU,
        CLS_UPPER,
        CLS_BRANCH,
        CLS_WB
    } alu_class_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_SLL   = 4'b0010;
    localparam logic [3:0] ALU_SLT   = 4'b0011;
    localparam logic [3:0] ALU_SLTU  = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_OR    = 4'b1000;
    localparam logic [3:0] ALU_AND   = 4'b1001;
    localparam logic [3:0] ALU_AUIPC = 4'b1010;
    localparam logic [3:0] ALU_LUI   = 4'b1011;
    localparam logic [3:0] ALU_PC4   = 4'b1100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] imm_src;
    } ctrl_t;

    // Moore outputs of a state; the opcode only refines MEMADR and ALUWB.
    function automatic ctrl_t state_outputs(state_t s, logic [6:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_write   = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.imm_src   = IMM_B;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD:  c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = RES_READDATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
            end
            S_EXECI: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.imm_src   = IMM_I;
            end
            S_EXECU: begin
                c.alu_src_b = SRCB_IMM;
                c.imm_src   = IMM_U;
            end
            S_JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALUOUT;
                c.pc_write   = 1'b1;
            end
            S_JALR: begin
                c.alu_src_a  = SRCA_RS1;
                c.alu_src_b  = SRCB_IMM;
                c.imm_src    = IMM_I;
                c.result_src = RES_ALURESULT;
                c.pc_write   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a  = SRCA_RS1;
                c.alu_src_b  = SRCB_RS2;
                c.result_src = RES_ALUOUT;
            end
            S_ALUWB: begin
                c.reg_write  = 1'b1;
                c.result_src = (op == OP_JALR) ? RES_ALURESULT : RES_ALUOUT;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-to-datapath bundle: instruction/flag inputs and all control outputs.
// master = control unit, slave = datapath.
interface multicycle_control_if #(
    parameter int ALU_CTRL_WIDTH = 4,
    parameter int INSTR_WIDTH    = 32
);
    logic [INSTR_WIDTH-1:0]    Instr;
    logic                      Zero;
    logic                      PCWrite;
    logic                      AdrSrc;
    logic                      MemWrite;
    logic                      IRWrite;
    logic                      RegWrite;
    logic [1:0]                ResultSrc;
    logic [1:0]                ALUSrcA;
    logic [1:0]                ALUSrcB;
    logic [2:0]                ImmSrc;
    logic [ALU_CTRL_WIDTH-1:0] ALUControl;
    logic                      IllegalInstr;

    modport master (
        input  Instr, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalInstr
    );

    modport slave (
        output Instr, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalInstr
    );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU-code decoder: maps the current state class and
// instruction fields to the 4-bit ALUControl code.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  alu_class_t i_class,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output logic [3:0] o_alu_control
);

    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_class)
            CLS_ALU: begin
                case (i_funct3)
                    3'b000:  o_alu_control = (i_opcode == OP_R && i_funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  o_alu_control = ALU_SLL;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b011:  o_alu_control = ALU_SLTU;
                    3'b100:  o_alu_control = ALU_XOR;
                    3'b101:  o_alu_control = i_funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  o_alu_control = ALU_OR;
                    default: o_alu_control = ALU_AND;
                endcase
            end
            CLS_UPPER:  o_alu_control = (i_opcode == OP_LUI) ? ALU_LUI : ALU_AUIPC;
            CLS_BRANCH: begin
                case (i_funct3[2:1])
                    2'b10:   o_alu_control = ALU_SLT;
                    2'b11:   o_alu_control = ALU_SLTU;
                    default: o_alu_control = ALU_SUB;
                endcase
            end
            // jalr's own ALU result was the jump target, so rd needs OldPC+4 here.
            CLS_WB:     o_alu_control = (i_opcode == OP_JALR) ? ALU_PC4 : ALU_ADD;
            default:    o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control unit: Moore FSM with registered outputs plus
// the ALU-code decoder; the branch PCWrite is the only Zero-dependent output.
module multicycle_control
    import rv_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_WIDTH = 4,
    parameter int INSTR_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master ctrl_bus
);

    state_t     r_state;
    ctrl_t      r_ctrl;
    logic       r_illegal;

    state_t     w_next;
    ctrl_t      w_next_ctrl;
    logic       w_illegal_next;
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_funct7_5;
    logic       w_branch_bad;
    logic       w_branch_take;
    alu_class_t w_class;
    logic [3:0] w_alu_ctrl;
    logic       w_unused;

    assign w_opcode     = ctrl_bus.Instr[6:0];
    assign w_funct3     = ctrl_bus.Instr[14:12];
    assign w_funct7_5   = ctrl_bus.Instr[INSTR_WIDTH-2];
    assign w_branch_bad = (w_funct3[2:1] == 2'b01);
    assign w_unused     = ^{ctrl_bus.Instr[INSTR_WIDTH-1], ctrl_bus.Instr[INSTR_WIDTH-3:15],
                            ctrl_bus.Instr[11:7]};

    always_comb begin
        w_next         = S_FETCH;
        w_illegal_next = 1'b0;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (w_opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = S_EXECR;
                    OP_I:              w_next = S_EXECI;
                    OP_LUI, OP_AUIPC:  w_next = S_EXECU;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR;
                    OP_BRANCH:         w_next = S_BRANCH;
                    default:           w_illegal_next = 1'b1;
                endcase
            end
            S_MEMADR:  w_next = (w_opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: w_next = S_MEMWB;
            S_EXECR, S_EXECI, S_EXECU, S_JAL, S_JALR: w_next = S_ALUWB;
            S_BRANCH:  w_illegal_next = w_branch_bad;
            default:   w_next = S_FETCH;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    assign w_next_ctrl = state_outputs(w_next, w_opcode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_ctrl    <= state_outputs(S_FETCH, '0);
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_ctrl    <= w_next_ctrl;
            r_illegal <= w_illegal_next;
        end
    end

    always_comb begin
        case (r_state)
            S_EXECR, S_EXECI: w_class = CLS_ALU;
            S_EXECU:          w_class = CLS_UPPER;
            S_BRANCH:         w_class = CLS_BRANCH;
            S_ALUWB:          w_class = CLS_WB;
            default:          w_class = CLS_ADD;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_class       (w_class),
        .i_opcode      (w_opcode),
        .i_funct3      (w_funct3),
        .i_funct7_5    (w_funct7_5),
        .o_alu_control (w_alu_ctrl)
    );

    assign w_branch_take = (r_state == S_BRANCH) && !w_branch_bad
                           && (ctrl_bus.Zero ^ w_funct3[0] ^ w_funct3[2]);

    // Reset holds FETCH values in the registers, so strobes are gated by rst directly.
    assign ctrl_bus.PCWrite      = ~rst & (r_ctrl.pc_write | w_branch_take);
    assign ctrl_bus.IRWrite      = ~rst & r_ctrl.ir_write;
    assign ctrl_bus.RegWrite     = ~rst & r_ctrl.reg_write;
    assign ctrl_bus.MemWrite     = ~rst & r_ctrl.mem_write;
    assign ctrl_bus.IllegalInstr = ~rst & r_illegal;
    assign ctrl_bus.AdrSrc       = r_ctrl.adr_src;
    assign ctrl_bus.ResultSrc    = r_ctrl.result_src;
    assign ctrl_bus.ALUSrcA      = r_ctrl.alu_src_a;
    assign ctrl_bus.ALUSrcB      = r_ctrl.alu_src_b;
    assign ctrl_bus.ImmSrc       = r_ctrl.imm_src;
    assign ctrl_bus.ALUControl   = ALU_CTRL_WIDTH'(w_alu_ctrl);

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed instructions plus random
// instruction streams compared cycle by cycle against a per-instruction trace model.
module tb_multicycle_control;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic       regw;
        logic       ill;
        logic [1:0] res;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] imm;
        logic [3:0] alu;
    } obs_t;

    logic clk;
    logic rst;
    int unsigned n_assert;
    int unsigned n_fail;
    bit   pend_ill;
    bit   next_ill;
    obs_t e_q[$];
    obs_t c_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_if #(.ALU_CTRL_WIDTH(4), .INSTR_WIDTH(32)) bus ();

    multicycle_control #(.ALU_CTRL_WIDTH(4), .INSTR_WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .ctrl_bus (bus)
    );

    function automatic obs_t sample();
        obs_t o;
        o.pcw  = bus.PCWrite;
        o.adr  = bus.AdrSrc;
        o.memw = bus.MemWrite;
        o.irw  = bus.IRWrite;
        o.regw = bus.RegWrite;
        o.ill  = bus.IllegalInstr;
        o.res  = bus.ResultSrc;
        o.sa   = bus.ALUSrcA;
        o.sb   = bus.ALUSrcB;
        o.imm  = bus.ImmSrc;
        o.alu  = bus.ALUControl;
        return o;
    endfunction

    // Strobes are always checked; selects only where the cycle defines them.
    function automatic obs_t care(bit adr, bit res, bit sa, bit sb, bit imm, bit alu);
        obs_t c;
        c = '0;
        c.pcw = 1'b1; c.memw = 1'b1; c.irw = 1'b1; c.regw = 1'b1; c.ill = 1'b1;
        c.adr = adr;
        c.res = {2{res}};
        c.sa  = {2{sa}};
        c.sb  = {2{sb}};
        c.imm = {3{imm}};
        c.alu = {4{alu}};
        return c;
    endfunction

    function automatic logic [3:0] alu_op(logic [2:0] f3, logic b30, bit is_r);
        case (f3)
            3'd0:    return (is_r && b30) ? 4'd1 : 4'd0;
            3'd1:    return 4'd2;
            3'd2:    return 4'd3;
            3'd3:    return 4'd4;
            3'd4:    return 4'd5;
            3'd5:    return b30 ? 4'd7 : 4'd6;
            3'd6:    return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    task automatic push(input obs_t e, input obs_t c);
        e_q.push_back(e);
        c_q.push_back(c);
    endtask

    // Expected per-cycle outputs of one instruction, FETCH first.
    task automatic build(input logic [31:0] ins, input logic z);
        obs_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic b30;
        op = ins[6:0];
        f3 = ins[14:12];
        b30 = ins[30];
        e_q.delete();
        c_q.delete();
        next_ill = 1'b0;
        e = '0; e.pcw = 1; e.irw = 1; e.ill = pend_ill; e.res = 2; e.sb = 2;
        push(e, care(1, 1, 1, 1, 0, 1));
        e = '0; e.sa = 1; e.sb = 1; e.imm = 3'd2;
        push(e, care(0, 0, 1, 1, 1, 1));
        case (op)
            7'b0000011: begin
                e = '0; e.sa = 2; e.sb = 1; e.imm = 0; push(e, care(0, 0, 1, 1, 1, 1));
                e = '0; e.adr = 1;                    push(e, care(1, 0, 0, 0, 0, 0));
                e = '0; e.res = 1; e.regw = 1;        push(e, care(0, 1, 0, 0, 0, 0));
            end
            7'b0100011: begin
                e = '0; e.sa = 2; e.sb = 1; e.imm = 1; push(e, care(0, 0, 1, 1, 1, 1));
                e = '0; e.adr = 1; e.memw = 1;        push(e, care(1, 0, 0, 0, 0, 0));
            end
            7'b0110011, 7'b0010011: begin
                e = '0; e.sa = 2;
                e.sb = (op == 7'b0110011) ? 2'd0 : 2'd1;
                e.alu = alu_op(f3, b30, op == 7'b0110011);
                push(e, care(0, 0, 1, 1, op == 7'b0010011, 1));
                e = '0; e.regw = 1; e.res = 0;        push(e, care(0, 1, 0, 0, 0, 0));
            end
            7'b0110111, 7'b0010111: begin
                e = '0; e.sb = 1; e.imm = 3'd4;
                e.alu = (op == 7'b0110111) ? 4'd11 : 4'd10;
                push(e, care(0, 0, 0, 1, 1, 1));
                e = '0; e.regw = 1; e.res = 0;        push(e, care(0, 1, 0, 0, 0, 0));
            end
            7'b1101111: begin
                e = '0; e.sa = 1; e.sb = 2; e.res = 0; e.pcw = 1; push(e, care(0, 1, 1, 1, 0, 1));
                e = '0; e.regw = 1; e.res = 0;        push(e, care(0, 1, 0, 0, 0, 0));
            end
            7'b1100111: begin
                e = '0; e.sa = 2; e.sb = 1; e.imm = 0; e.res = 2; e.pcw = 1;
                push(e, care(0, 1, 1, 1, 1, 1));
                e = '0; e.regw = 1; e.res = 2; e.alu = 4'd12; push(e, care(0, 1, 0, 0, 0, 1));
            end
            7'b1100011: begin
                e = '0; e.sa = 2; e.sb = 0; e.res = 0;
                case (f3)
                    3'd0:    begin e.alu = 1; e.pcw = z;  end
                    3'd1:    begin e.alu = 1; e.pcw = !z; end
                    3'd4:    begin e.alu = 3; e.pcw = !z; end
                    3'd5:    begin e.alu = 3; e.pcw = z;  end
                    3'd6:    begin e.alu = 4; e.pcw = !z; end
                    3'd7:    begin e.alu = 4; e.pcw = z;  end
                    default: begin e.pcw = 0; next_ill = 1'b1; end
                endcase
                push(e, care(0, 1, 1, 1, 0, f3[2:1] != 2'b01));
            end
            default: next_ill = 1'b1;
        endcase
    endtask

    // Starts at posedge+1 of the FETCH cycle, ends at the negedge of the last checked cycle.
    task automatic run_instr(input logic [31:0] ins, input logic z, input int unsigned ncyc,
                             input string tag);
        obs_t o;
        int unsigned n;
        build(ins, z);
        n = (ncyc < e_q.size()) ? ncyc : e_q.size();
        for (int unsigned i = 0; i < n; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (i == 1) bus.Instr = ins;
            bus.Zero = (i == 2) ? z : 1'($urandom_range(0, 1));
            @(negedge clk);
            o = sample();
            n_assert++;
            assert ((o & c_q[i]) === (e_q[i] & c_q[i])) else begin
                n_fail++;
                $error("FAIL %s[%0d] instr=%h: observed %h expected %h care %h",
                       tag, i, ins, o, e_q[i], c_q[i]);
            end
        end
        if (n == e_q.size()) pend_ill = next_ill;
    endtask

    task automatic do_instr(input logic [31:0] ins, input logic z, input string tag);
        @(posedge clk);
        #1;
        run_instr(ins, z, 99, tag);
    endtask

    task automatic check_reset(input string tag);
        obs_t o;
        obs_t e;
        obs_t c;
        e = '0; e.res = 2; e.sb = 2;
        c = care(1, 1, 1, 1, 0, 1);
        o = sample();
        n_assert++;
        assert ((o & c) === (e & c)) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h care %h", tag, o, e, c);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0] bad [5];
        bad = '{7'h7F, 7'h0F, 7'h73, 7'h00, 7'h2F};
        r = $urandom;
        case ($urandom_range(0, 10))
            0:  begin r[6:0] = 7'b0000011; r[14:12] = 3'b010; end
            1:  begin r[6:0] = 7'b0100011; r[14:12] = 3'b010; end
            2:  begin r[6:0] = 7'b0110011; r[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
            3:  r[6:0] = 7'b0010011;
            4:  r[6:0] = 7'b0110111;
            5:  r[6:0] = 7'b0010111;
            6:  r[6:0] = 7'b1101111;
            7:  begin r[6:0] = 7'b1100111; r[14:12] = 3'b000; end
            8, 9: r[6:0] = 7'b1100011;
            default: r[6:0] = bad[$urandom_range(0, 4)];
        endcase
        return r;
    endfunction

    initial begin
        n_assert = 0;
        n_fail   = 0;
        pend_ill = 1'b0;
        next_ill = 1'b0;
        bus.Instr = '0;
        bus.Zero  = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset("reset_async");
        @(negedge clk);
        check_reset("reset_hold");
        @(posedge clk);
        #1 rst = 1'b0;

        run_instr(32'h402081B3, 1'b0, 99, "sub");
        do_instr(32'h0080A283, 1'b0, "lw");
        do_instr(32'h0020D063, 1'b1, "bge_zero1");
        do_instr(32'h0020D063, 1'b0, "bge_zero0");
        do_instr(32'h123453B7, 1'b0, "lui");
        do_instr(32'h0000007F, 1'b0, "illegal_op");
        do_instr(32'h00508093, 1'b0, "addi_after_illegal");
        do_instr(32'h0020A063, 1'b1, "branch_f3_010");
        do_instr(32'hFFF08093, 1'b0, "addi_neg_imm");

        // Abort an R-type in EXECR with an asynchronous reset.
        @(posedge clk);
        #1;
        run_instr(32'h402081B3, 1'b0, 3, "sub_abort");
        #2 rst = 1'b1;
        #1 check_reset("reset_mid_execr");
        @(posedge clk);
        #1 check_reset("reset_mid_held");
        rst = 1'b0;
        pend_ill = 1'b0;
        run_instr(32'h001101B3, 1'b0, 99, "add_after_reset");

        for (int i = 0; i < 80; i++) begin
            do_instr(rand_instr(), 1'($urandom_range(0, 1)), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
